// File: rtl/peri_router_pkg.sv
// rtl/peri_router_pkg.sv - pipeconnect bundle types and router constants
package peri_router_pkg;

   typedef struct packed {
      logic [31:0] a;
      logic        r;
      logic        w;
      logic [31:0] wd;
      logic [3:0]  wbe;
   } peri_req_t;

   typedef struct packed {
      logic        hold;
      logic [31:0] rd;
   } peri_res_t;

   localparam int REQ_W = $bits(peri_req_t);
   localparam int RES_W = $bits(peri_res_t);

   localparam int PERI_ERR_UNMAPPED = 0;
   localparam int PERI_ERR_TIMEOUT  = 1;

   localparam int HOLD_CNT_W = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/peri_timeout.sv
// rtl/peri_timeout.sv - stall watchdog: aborts a target holding HOLD for TIMEOUT cycles
module peri_timeout
   import peri_router_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic hold,
   output logic abort
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;

   localparam logic [HOLD_CNT_W-1:0] LIMIT = HOLD_CNT_W'(TIMEOUT);

   logic [1:0]            state;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [HOLD_CNT_W-1:0] cnt_next;

   // hold_cnt counts stalled cycles already shown to the master; the master sees exactly TIMEOUT of them
   assign cnt_next = (state == S_IDLE) ? HOLD_CNT_W'(1) : hold_cnt + HOLD_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (active && hold) begin
                  hold_cnt <= cnt_next;
                  state    <= (cnt_next == LIMIT) ? S_ABORT : S_WAIT;
               end
            end
            S_WAIT: begin
               if (active && hold) begin
                  hold_cnt <= cnt_next;
                  if (cnt_next == LIMIT) begin
                     state <= S_ABORT;
                  end
               end else begin
                  state    <= S_IDLE;
                  hold_cnt <= '0;
               end
            end
            S_ABORT: begin
               state    <= S_IDLE;
               hold_cnt <= '0;
            end
            default: begin
               state    <= S_IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   assign abort = (state == S_ABORT);

endmodule

// File: rtl/peri_router.sv
// rtl/peri_router.sv - decodes the FF00_xxxx window to NT pipeconnect targets
// with local error replies, stall abort and error bookkeeping
module peri_router
   import peri_router_pkg::*;
#(
   parameter int          NT        = 4,
   parameter int          SLOT_BITS = 12,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
   parameter int          CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REQ_W-1:0]    peripheral_req,
   output logic [RES_W-1:0]    peripheral_res,
   output logic [NT*REQ_W-1:0] tgt_req,
   input  logic [NT*RES_W-1:0] tgt_res,
   output logic [1:0]          err_sticky,
   output logic [CNT_W-1:0]    err_count
);

   localparam int SEL_W = 16 - SLOT_BITS;
   localparam int IDX_W = idx_width(NT);

   peri_req_t        req;
   peri_res_t        tres [NT];
   logic [SEL_W-1:0] sel;
   logic             mapped;
   logic             strobe;
   logic             go;
   logic             tgt_hold;
   logic             hold;
   logic             accept;
   logic             abort;
   logic             unmapped_ev;
   logic             err_ev;
   logic [IDX_W-1:0] rd_sel;
   logic             rd_err;
   logic             pending;
   logic [31:0]      tgt_rd;
   logic [31:0]      rd_out;

   assign req    = peripheral_req;
   assign sel    = req.a[15:SLOT_BITS];
   assign mapped = (32'(sel) < 32'(NT));
   assign strobe = (req.r | req.w) & ~rst;
   assign go     = strobe & mapped & ~abort;

   for (genvar k = 0; k < NT; k++) begin : g_slice
      assign tres[k] = tgt_res[k*RES_W +: RES_W];
      assign tgt_req[k*REQ_W +: REQ_W] = {req.a,
                                          req.r & go & (32'(sel) == 32'(k)),
                                          req.w & go & (32'(sel) == 32'(k)),
                                          req.wd,
                                          req.wbe};
   end

   always_comb begin
      tgt_hold = 1'b0;
      for (int k = 0; k < NT; k++) begin
         if (32'(sel) == 32'(k)) begin
            tgt_hold = tres[k].hold;
         end
      end
   end

   assign hold        = go & tgt_hold;
   assign accept      = strobe & ~hold;
   assign unmapped_ev = accept & ~mapped;
   assign err_ev      = unmapped_ev | abort;

   peri_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .active (strobe & mapped),
      .hold   (tgt_hold),
      .abort  (abort)
   );

   // an aborted read is completed locally, so it returns ERR_DATA like an unmapped one
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         rd_sel  <= '0;
         rd_err  <= 1'b0;
      end else begin
         pending <= accept & req.r;
         if (accept && req.r) begin
            rd_sel <= IDX_W'(sel);
            rd_err <= ~mapped | abort;
         end
      end
   end

   always_comb begin
      tgt_rd = '0;
      for (int k = 0; k < NT; k++) begin
         if (32'(rd_sel) == 32'(k)) begin
            tgt_rd = tres[k].rd;
         end
      end
   end

   assign rd_out         = !pending ? 32'h0 : (rd_err ? ERR_DATA : tgt_rd);
   assign peripheral_res = {hold, rd_out};

   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky <= '0;
         err_count  <= '0;
      end else begin
         if (unmapped_ev) begin
            err_sticky[PERI_ERR_UNMAPPED] <= 1'b1;
         end
         if (abort) begin
            err_sticky[PERI_ERR_TIMEOUT] <= 1'b1;
         end
         if (err_ev && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

`ifdef SIMULATE_MAIN
   pipechecker u_chk_master (
      .clk (clk),
      .rst (rst),
      .req (peripheral_req),
      .res (peripheral_res)
   );
   for (genvar k = 0; k < NT; k++) begin : g_chk
      pipechecker u_chk_tgt (
         .clk (clk),
         .rst (rst),
         .req (tgt_req[k*REQ_W +: REQ_W]),
         .res (tgt_res[k*RES_W +: RES_W])
      );
   end
`endif

endmodule

// File: tb/tb_peri_router.sv
// tb/tb_peri_router.sv - self-checking bench for peri_router with behavioural targets
`timescale 1ns/1ps
module tb_peri_router;
   import peri_router_pkg::*;

   localparam int          NT        = 4;
   localparam int          SLOT_BITS = 12;
   localparam int          TMO       = 8;
   localparam int          CNT_W     = 4;
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;
   localparam logic [31:0] ERR       = 32'hDEADBEEF;

   logic                clk = 1'b0;
   logic                rst;
   logic [REQ_W-1:0]    peripheral_req;
   logic [RES_W-1:0]    peripheral_res;
   logic [NT*REQ_W-1:0] tgt_req;
   logic [NT*RES_W-1:0] tgt_res;
   logic [1:0]          err_sticky;
   logic [CNT_W-1:0]    err_count;

   peri_router #(
      .NT(NT), .SLOT_BITS(SLOT_BITS), .TIMEOUT(TMO), .ERR_DATA(ERR), .CNT_W(CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .peripheral_req (peripheral_req),
      .peripheral_res (peripheral_res),
      .tgt_req        (tgt_req),
      .tgt_res        (tgt_res),
      .err_sticky     (err_sticky),
      .err_count      (err_count)
   );

   always #5 clk = ~clk;

   peri_req_t mreq;
   peri_res_t mres;
   assign peripheral_req = mreq;
   assign mres           = peripheral_res;

   // targets: stall_cfg[k] HOLD cycles per request (-1 = forever), read data tdata[k] captured at accept
   peri_req_t   treq [NT];
   int          stall_cfg [NT];
   logic [31:0] tdata [NT];
   int          busy [NT] = '{default: 0};
   logic [31:0] rd_q [NT] = '{default: 32'h0};
   logic [NT-1:0] t_stb, t_hold;

   always_comb begin
      t_stb   = '0;
      t_hold  = '0;
      tgt_res = '0;
      for (int k = 0; k < NT; k++) begin
         treq[k]   = tgt_req[k*REQ_W +: REQ_W];
         t_stb[k]  = treq[k].r | treq[k].w;
         t_hold[k] = t_stb[k] && (stall_cfg[k] < 0 || busy[k] < stall_cfg[k]);
         tgt_res[k*RES_W +: RES_W] = {t_hold[k], rd_q[k]};
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NT; k++) begin
         if (t_stb[k] && t_hold[k]) begin
            busy[k] <= busy[k] + 1;
         end else begin
            busy[k] <= 0;
            if (t_stb[k] && treq[k].r) rd_q[k] <= tdata[k];
         end
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        exp_rd_v;
   logic [31:0] exp_rd_d;
   int          m_cnt;
   logic [1:0]  m_sticky;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sample_common(input string tag);
      check({tag, " rd"}, mres.rd, exp_rd_v ? exp_rd_d : 32'h0);
      check({tag, " err_count"}, 32'(err_count), 32'(m_cnt));
      check({tag, " err_sticky"}, 32'(err_sticky), 32'(m_sticky));
   endtask

   task automatic check_no_strobe(input string tag);
      for (int k = 0; k < NT; k++) begin
         check({tag, " tgt_rw"}, 32'({treq[k].r, treq[k].w}), 32'h0);
      end
   endtask

   task automatic xfer(input logic [31:0] addr, input logic rd, input int stall, input logic [31:0] data,
                       input int e_hold, input logic [31:0] e_rd, input int e_tgt, input int e_cnt,
                       input logic [1:0] e_st, input string tag);
      int sel;
      sel = int'(addr[15:12]);
      if (sel < NT) begin
         stall_cfg[sel] = stall;
         tdata[sel]     = data;
      end
      mreq = '{a: addr, r: rd, w: !rd, wd: $urandom, wbe: 4'($urandom)};
      for (int i = 0; i <= e_hold; i++) begin
         #1;
         sample_common(tag);
         exp_rd_v = 1'b0;
         check({tag, " hold"}, 32'(mres.hold), (i < e_hold) ? 32'h1 : 32'h0);
         if (i == e_hold) begin
            for (int k = 0; k < NT; k++) begin
               check({tag, " tgt_r"}, 32'(treq[k].r), 32'((k == e_tgt) && rd));
               check({tag, " tgt_w"}, 32'(treq[k].w), 32'((k == e_tgt) && !rd));
               check({tag, " tgt_a"}, treq[k].a, addr);
            end
            if (rd) begin
               exp_rd_v = 1'b1;
               exp_rd_d = e_rd;
            end
            m_cnt    = e_cnt;
            m_sticky = e_st;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n, input string tag);
      mreq.r = 1'b0;
      mreq.w = 1'b0;
      repeat (n) begin
         #1;
         sample_common(tag);
         exp_rd_v = 1'b0;
         check({tag, " idle hold"}, 32'(mres.hold), 32'h0);
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      int          stall;
      logic [31:0] data;
      int          e_hold;
      logic [31:0] e_rd;
      int          e_tgt;
      int          e_cnt;
      logic [1:0]  e_st;
      int          gap;
   } vec_t;

   vec_t vt [13];

   initial begin
      vt[0]  = '{32'hFF00_1004, 1'b1,  0, 32'h1234_5678, 0,   32'h1234_5678,  1, 0, 2'b00, 1};
      vt[1]  = '{32'hFF00_0010, 1'b1,  7, 32'hCAFE_0001, 7,   32'hCAFE_0001,  0, 0, 2'b00, 1};
      vt[2]  = '{32'hFF00_3000, 1'b1,  0, 32'hA000_0003, 0,   32'hA000_0003,  3, 0, 2'b00, 0};
      vt[3]  = '{32'hFF00_0004, 1'b1,  0, 32'hB000_0000, 0,   32'hB000_0000,  0, 0, 2'b00, 0};
      vt[4]  = '{32'hFF00_3008, 1'b1,  0, 32'hA000_0033, 0,   32'hA000_0033,  3, 0, 2'b00, 1};
      vt[5]  = '{32'hFF00_2100, 1'b0,  3, 32'h0,         3,   32'h0,          2, 0, 2'b00, 1};
      vt[6]  = '{32'hFF00_5000, 1'b0,  0, 32'h0,         0,   32'h0,         -1, 1, 2'b01, 0};
      vt[7]  = '{32'hFF00_7000, 1'b1,  0, 32'h0,         0,   ERR,           -1, 2, 2'b01, 1};
      vt[8]  = '{32'hFF00_2000, 1'b1, -1, 32'h0,         TMO, ERR,           -1, 3, 2'b11, 1};
      vt[9]  = '{32'hFF00_1000, 1'b1,  8, 32'h1111_0000, TMO, ERR,           -1, 4, 2'b11, 1};
      vt[10] = '{32'hFF00_F000, 1'b0,  0, 32'h0,         0,   32'h0,         -1, 5, 2'b11, 0};
      vt[11] = '{32'hFF00_1FFC, 1'b1,  0, 32'h55AA_55AA, 0,   32'h55AA_55AA,  1, 5, 2'b11, 1};
      vt[12] = '{32'hFF00_4000, 1'b1,  0, 32'h0,         0,   ERR,           -1, 6, 2'b11, 1};

      for (int k = 0; k < NT; k++) begin
         stall_cfg[k] = 0;
         tdata[k]     = 32'h0;
      end
      exp_rd_v = 1'b0;
      exp_rd_d = 32'h0;
      m_cnt    = 0;
      m_sticky = 2'b00;

      // request present during reset must not reach any target
      rst  = 1'b1;
      mreq = '{a: 32'hFF00_1000, r: 1'b1, w: 1'b0, wd: 32'h0, wbe: 4'hF};
      @(negedge clk);
      repeat (2) begin
         #1;
         sample_common("reset");
         check("reset hold", 32'(mres.hold), 32'h0);
         check_no_strobe("reset");
         @(negedge clk);
      end
      rst = 1'b0;
      idle(1, "post_reset");

      for (int v = 0; v < 13; v++) begin
         xfer(vt[v].addr, vt[v].rd, vt[v].stall, vt[v].data, vt[v].e_hold, vt[v].e_rd,
              vt[v].e_tgt, vt[v].e_cnt, vt[v].e_st, $sformatf("vec%0d", v));
         if (vt[v].gap > 0) idle(vt[v].gap, $sformatf("vec%0d gap", v));
      end

      for (int t = 0; t < 200; t++) begin
         int          sel, stall, eh, ecnt, etgt, pick;
         logic        rd, mapped, tmo, err;
         logic [31:0] addr, data, erd;
         logic [1:0]  est;
         sel  = $urandom_range(0, 7);
         addr = 32'hFF00_0000 | (32'(sel) << 12) | (32'($urandom) & 32'h0000_0FFC);
         rd   = 1'($urandom);
         data = $urandom;
         pick = $urandom_range(0, 9);
         if (pick < 4)       stall = 0;
         else if (pick == 4) stall = 1;
         else if (pick == 5) stall = TMO - 1;
         else if (pick == 6) stall = TMO;
         else if (pick == 7) stall = -1;
         else                stall = $urandom_range(0, 12);
         mapped = (sel < NT);
         tmo    = mapped && (stall < 0 || stall >= TMO);
         err    = !mapped || tmo;
         eh     = !mapped ? 0 : (tmo ? TMO : stall);
         erd    = err ? ERR : data;
         etgt   = err ? -1 : sel;
         ecnt   = err ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX) : m_cnt;
         est    = m_sticky | {tmo, !mapped};
         xfer(addr, rd, stall, data, eh, erd, etgt, ecnt, est, $sformatf("rnd%0d", t));
         if ($urandom_range(0, 1) == 1) idle(1, "rnd gap");
      end
      idle(1, "rnd end");

      // reset in the middle of a stall at hold_cnt=5
      stall_cfg[2] = -1;
      mreq = '{a: 32'hFF00_2000, r: 1'b1, w: 1'b0, wd: 32'h0, wbe: 4'hF};
      for (int i = 0; i < 5; i++) begin
         #1;
         sample_common("stall6");
         check("stall6 hold", 32'(mres.hold), 32'h1);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("rst6 in-reset hold", 32'(mres.hold), 32'h0);
      check_no_strobe("rst6 in-reset");
      @(negedge clk);
      rst      = 1'b0;
      mreq.r   = 1'b0;
      m_cnt    = 0;
      m_sticky = 2'b00;
      exp_rd_v = 1'b0;
      #1;
      sample_common("rst6 after");
      check("rst6 after hold", 32'(mres.hold), 32'h0);
      check_no_strobe("rst6 after");
      @(negedge clk);
      xfer(32'hFF00_2040, 1'b1, 0, 32'h7766_5544, 0, 32'h7766_5544, 2, 0, 2'b00, "post_rst6");
      idle(2, "final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
